// File: rtl/uart_receiver_pkg.sv
// rtl/uart_receiver_pkg.sv - shared UART frame definitions
// Purpose: state encoding and default frame geometry shared by the UART
//          receiver and the future transmitter.
// Ports:   none (package).
package uart_receiver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for an asynchronous input
// Purpose: brings an asynchronous level into the clock domain.
// Ports:
//   clock  in   system clock
//   reset  in   synchronous active-high reset, loads RESET_VAL into both flops
//   d      in   asynchronous input
//   q      out  synchronised output (two clocks of latency)
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with 16x oversampling
// Purpose: recovers bytes from the rx line by mid-bit sampling and presents
//          each with a one-clock valid strobe, or a one-clock framing error.
// Ports:
//   clock          in   system clock
//   reset          in   synchronous active-high reset
//   enb_rx         in   one-clock oversample tick
//   rx             in   asynchronous serial line, idle high
//   data_out       out  last correctly framed byte
//   data_valid     out  one-clock pulse, data_out updated
//   framing_error  out  one-clock pulse, stop bit sampled low
//   busy           out  high from start-bit detect until return to IDLE
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enb_rx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  uart_state_t          state, state_n;
  logic [CW-1:0]        tick_cnt, tick_n;
  logic [BW-1:0]        bit_idx, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] dout_n;
  logic                 armed, armed_n;
  logic                 busy_n, dv_n, fe_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      armed         <= 1'b1;
      busy          <= 1'b0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state         <= state_n;
      tick_cnt      <= tick_n;
      bit_idx       <= bit_n;
      shift         <= shift_n;
      armed         <= armed_n;
      busy          <= busy_n;
      data_out      <= dout_n;
      data_valid    <= dv_n;
      framing_error <= fe_n;
    end
  end

  // Everything holds between ticks except the two pulse outputs, which
  // default low so they last exactly one clock.
  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    armed_n = armed;
    busy_n  = busy;
    dout_n  = data_out;
    dv_n    = 1'b0;
    fe_n    = 1'b0;

    if (enb_rx) begin
      unique case (state)
        IDLE: begin
          // armed only clears on a framing error; a held-low break must be
          // seen high once before a new start edge counts.
          if (rx_s) armed_n = 1'b1;
          if (armed && !rx_s) begin
            state_n = START;
            tick_n  = '0;
            busy_n  = 1'b1;
          end
        end

        START: begin
          tick_n = tick_cnt + CW'(1);
          if (tick_cnt == HALF_M1) begin
            tick_n = '0;
            if (!rx_s) begin
              state_n = DATA;
              bit_n   = '0;
            end else begin
              // Line went back high before mid start bit: a glitch.
              state_n = IDLE;
              busy_n  = 1'b0;
            end
          end
        end

        DATA: begin
          tick_n = tick_cnt + CW'(1);
          if (tick_cnt == FULL_M1) begin
            tick_n  = '0;
            shift_n = {rx_s, shift[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) state_n = STOP;
            else                     bit_n   = bit_idx + BW'(1);
          end
        end

        STOP: begin
          tick_n = tick_cnt + CW'(1);
          if (tick_cnt == FULL_M1) begin
            // Return to IDLE at mid stop bit so a following start edge in
            // the second half of the stop bit is still caught.
            tick_n  = '0;
            state_n = IDLE;
            busy_n  = 1'b0;
            if (rx_s) begin
              dout_n = shift;
              dv_n   = 1'b1;
            end else begin
              fe_n    = 1'b1;
              armed_n = 1'b0;
            end
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
module tb_uart_receiver;

  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = 16 * TICK_DIV;
  localparam int FRAME_CLKS = 10 * BIT_CLKS;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enb_rx = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_error;
  logic       busy;
  logic       tick_on = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       busy_at;
    logic       busy_before;
    int         cyc;
  } ev_t;

  ev_t        ev_q[$];
  ev_t        exp_q[$];
  int         ev_cyc_hist[$];
  logic [7:0] last_good = 8'h00;
  logic       busy_seen = 1'b0;
  logic       prev_dv = 1'b0, prev_fe = 1'b0, prev_busy = 1'b0;

  uart_receiver dut (
    .clock         (clock),
    .reset         (reset),
    .enb_rx        (enb_rx),
    .rx            (rx),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .framing_error (framing_error),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  initial begin
    forever begin
      repeat (TICK_DIV - 1) @(posedge clock);
      #1 enb_rx = tick_on;
      @(posedge clock);
      #1 enb_rx = 1'b0;
    end
  end

  // kind: 0 valid, 1 framing error, 2 pulse longer than one clock, 3 both at once
  always @(negedge clock) begin
    ev_t e;
    if (data_valid === 1'b1 || framing_error === 1'b1) begin
      if (data_valid === 1'b1 && framing_error === 1'b1) e.kind = 3;
      else if ((data_valid && prev_dv) || (framing_error && prev_fe)) e.kind = 2;
      else if (data_valid === 1'b1) e.kind = 0;
      else e.kind = 1;
      e.data        = data_out;
      e.busy_at     = busy;
      e.busy_before = prev_busy;
      e.cyc         = cyc;
      ev_q.push_back(e);
    end
    prev_dv   = data_valid;
    prev_fe   = framing_error;
    prev_busy = busy;
    if (busy === 1'b1) busy_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_clks(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  // Reference model: a frame yields a valid byte when its stop bit is high,
  // otherwise a framing error that leaves the last good byte in place.
  task automatic model_frame(input logic [7:0] b, input logic stop);
    ev_t e;
    e.kind        = stop ? 0 : 1;
    e.data        = stop ? b : last_good;
    e.busy_at     = 1'b0;
    e.busy_before = 1'b1;
    e.cyc         = 0;
    if (stop) last_good = b;
    exp_q.push_back(e);
  endtask

  task automatic check_events(input string tag);
    ev_t x, o;
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk({tag, "_present"}, (ev_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (ev_q.size() > 0) begin
        o = ev_q.pop_front();
        chk({tag, "_kind"}, o.kind, x.kind);
        chk({tag, "_data"}, {24'd0, o.data}, {24'd0, x.data});
        chk({tag, "_busy_drop"}, {31'd0, o.busy_at}, {31'd0, x.busy_at});
        chk({tag, "_busy_before"}, {31'd0, o.busy_before}, {31'd0, x.busy_before});
        ev_cyc_hist.push_back(o.cyc);
      end
    end
    chk({tag, "_no_extra"}, ev_q.size(), 32'd0);
    ev_q.delete();
    chk({tag, "_data_out"}, {24'd0, data_out}, {24'd0, last_good});
  endtask

  initial begin
    logic [7:0] b;
    logic       stop;
    int         gap;
    int         n;

    wait_clks(6);
    reset = 1'b0;
    wait_clks(1);
    chk("rst_data_out", {24'd0, data_out}, 32'd0);
    chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_framing_error", {31'd0, framing_error}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    wait_clks(BIT_CLKS);

    // T1: single good frame
    send_frame(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b1);
    wait_clks(BIT_CLKS);
    check_events("t1");

    // T2: back-to-back frames with no idle gap
    ev_cyc_hist.delete();
    send_frame(8'h00, 1'b1);
    model_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    model_frame(8'hFF, 1'b1);
    wait_clks(BIT_CLKS);
    check_events("t2");
    n = ev_cyc_hist.size();
    chk("t2_spacing", (n == 2) ? (ev_cyc_hist[1] - ev_cyc_hist[0]) : 0, FRAME_CLKS);

    // T3: short low glitch must not produce a frame
    busy_seen = 1'b0;
    rx = 1'b0;
    wait_clks(4 * TICK_DIV);
    rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    chk("t3_busy_pulsed", {31'd0, busy_seen}, 32'd1);
    chk("t3_busy_low", {31'd0, busy}, 32'd0);
    check_events("t3_glitch");
    send_frame(8'h5A, 1'b1);
    model_frame(8'h5A, 1'b1);
    wait_clks(BIT_CLKS);
    check_events("t3");

    // T4: framing error followed by a held-low line
    send_frame(8'h3C, 1'b0);
    model_frame(8'h3C, 1'b0);
    busy_seen = 1'b0;
    wait_clks(2 * BIT_CLKS);
    chk("t4_no_retrigger", {31'd0, busy_seen}, 32'd0);
    rx = 1'b1;
    wait_clks(BIT_CLKS);
    check_events("t4_ferr");
    send_frame(8'h55, 1'b1);
    model_frame(8'h55, 1'b1);
    wait_clks(BIT_CLKS);
    check_events("t4");

    // T5: reset in the middle of a frame, just after bit 3 is sampled
    b = 8'hF0;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(b[i]);
    rx = b[3];
    wait_clks(44);
    reset = 1'b1;
    wait_clks(1);
    rx = 1'b1;
    reset = 1'b0;
    chk("t5_data_out", {24'd0, data_out}, 32'd0);
    chk("t5_data_valid", {31'd0, data_valid}, 32'd0);
    chk("t5_framing_error", {31'd0, framing_error}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    last_good = 8'h00;
    wait_clks(2 * BIT_CLKS);
    check_events("t5_abort");
    send_frame(8'h81, 1'b1);
    model_frame(8'h81, 1'b1);
    wait_clks(BIT_CLKS);
    check_events("t5");

    // T6: no ticks means no reception at all
    tick_on = 1'b0;
    wait_clks(2 * TICK_DIV);
    busy_seen = 1'b0;
    send_frame(8'h11, 1'b1);
    wait_clks(BIT_CLKS);
    chk("t6_busy", {31'd0, busy_seen}, 32'd0);
    check_events("t6");
    tick_on = 1'b1;
    wait_clks(BIT_CLKS);
    check_events("t6_resume");

    // Randomised frames with random stop bits and idle gaps
    for (int k = 0; k < 8; k++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      gap  = $urandom_range(0, 2);
      if (!stop && gap == 0) gap = 1;
      send_frame(b, stop);
      model_frame(b, stop);
      rx = 1'b1;
      wait_clks(gap * BIT_CLKS);
      check_events("rand");
    end
    wait_clks(BIT_CLKS);
    check_events("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
